regfile_alu_pipe: RTL and testbench

- Parametrised successor to the single-cycle register-file/ALU datapath.
- Accepts one micro-op per cycle over a valid/ready issue port and reads two operands, with an optional constant substituted for B. It executes in a registered stage and writes back on result acceptance.
- Forwards the in-flight result to dependent operations, keeps a sticky NZCV status register, and replaces the tri-state bus with a mux.
- Sits between the control unit/sequencer and the memory/IO datapath.

---
 rtl/regfile_alu_pkg.sv | 24 ++
 rtl/regfile_alu_pipe_alu.sv | 56 +++++
 rtl/regfile_alu_pipe.sv | 132 +++++++++++++
 tb/tb_regfile_alu_pipe.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_alu_pkg.sv
// Shared constants for the register-file/ALU pipeline: ALU op codes,
// invert-bit positions and status flag bit indices.
package regfile_alu_pkg;

  localparam int unsigned FS_W      = 5;
  localparam int unsigned FS_INV_B  = 0;
  localparam int unsigned FS_INV_A  = 1;
  localparam int unsigned FS_OP_LSB = 2;
  localparam int unsigned FS_OP_W   = 3;

  localparam logic [FS_OP_W-1:0] FS_AND = 3'b000;
  localparam logic [FS_OP_W-1:0] FS_OR  = 3'b001;
  localparam logic [FS_OP_W-1:0] FS_ADD = 3'b010;
  localparam logic [FS_OP_W-1:0] FS_XOR = 3'b011;
  localparam logic [FS_OP_W-1:0] FS_SHL = 3'b100;
  localparam logic [FS_OP_W-1:0] FS_SHR = 3'b101;

  localparam int unsigned FLAG_W = 4;
  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_C = 2;
  localparam int unsigned FLAG_V = 3;

endpackage

// File: rtl/regfile_alu_pipe_alu.sv
// Combinational ALU: optional operand inversion, logic/add/shift ops,
// and {V,C,N,Z} of the produced result.
module alu_param
  import regfile_alu_pkg::*;
#(
  parameter int unsigned DATA_W = 64
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [FS_W-1:0]   fs,
  input  logic              c0,
  output logic [DATA_W-1:0] f,
  output logic [FLAG_W-1:0] flags
);

  localparam int unsigned SHW = $clog2(DATA_W);

  logic [DATA_W-1:0] a_op;
  logic [DATA_W-1:0] b_op;
  logic [DATA_W:0]   sum;
  logic [FS_OP_W-1:0] op;
  logic              is_add;

  always_comb begin
    a_op   = fs[FS_INV_A] ? ~a : a;
    b_op   = fs[FS_INV_B] ? ~b : b;
    op     = fs[FS_OP_LSB +: FS_OP_W];
    sum    = (DATA_W+1)'(a_op) + (DATA_W+1)'(b_op) + (DATA_W+1)'(c0);
    is_add = 1'b0;
    f      = '0;
    case (op)
      FS_AND: f = a_op & b_op;
      FS_OR:  f = a_op | b_op;
      FS_ADD: begin
        f      = sum[DATA_W-1:0];
        is_add = 1'b1;
      end
      FS_XOR: f = a_op ^ b_op;
      // Shift amount wraps: only the low log2(DATA_W) bits are used
      FS_SHL: f = a_op << b_op[SHW-1:0];
      FS_SHR: f = a_op >> b_op[SHW-1:0];
      default: f = '0;
    endcase
  end

  always_comb begin
    flags         = '0;
    flags[FLAG_Z] = (f == '0);
    flags[FLAG_N] = f[DATA_W-1];
    if (is_add) begin
      flags[FLAG_C] = sum[DATA_W];
      flags[FLAG_V] = (a_op[DATA_W-1] == b_op[DATA_W-1]) && (f[DATA_W-1] != a_op[DATA_W-1]);
    end
  end

endmodule

// File: rtl/regfile_alu_pipe.sv
// Register file + ALU with a single registered execute stage, valid/ready
// issue and result ports, result forwarding and a sticky NZCV status register.
module regfile_alu_pipe
  import regfile_alu_pkg::*;
#(
  parameter  int unsigned DATA_W   = 64,
  parameter  int unsigned NREGS    = 32,
  parameter  int unsigned ZERO_REG = NREGS - 1,
  localparam int unsigned AW       = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [AW-1:0]     in_sa,
  input  logic [AW-1:0]     in_sb,
  input  logic [AW-1:0]     in_da,
  input  logic [FS_W-1:0]   in_fs,
  input  logic              in_c0,
  input  logic [DATA_W-1:0] in_k,
  input  logic              in_ksel,
  input  logic              in_dsel,
  input  logic              in_w,
  input  logic              in_sf,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [FLAG_W-1:0] out_flags,
  output logic [FLAG_W-1:0] status,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  // A ZERO_REG outside the register range disables the zero register
  function automatic logic is_zr(input logic [AW-1:0] addr);
    return (ZERO_REG < NREGS) && (32'(addr) == ZERO_REG);
  endfunction

  logic [DATA_W-1:0] regs [NREGS];
  logic [DATA_W-1:0] res_q;
  logic [FLAG_W-1:0] flags_q;
  logic [FLAG_W-1:0] status_q;
  logic [AW-1:0]     da_q;
  logic              w_q;
  logic              sf_q;
  logic              valid_q;

  logic              issue_fire;
  logic              res_fire;
  logic              fwd_en;
  logic [DATA_W-1:0] opa;
  logic [DATA_W-1:0] breg;
  logic [DATA_W-1:0] opb;
  logic [DATA_W-1:0] alu_f;
  logic [FLAG_W-1:0] alu_flags;
  logic [DATA_W-1:0] d;
  logic [FLAG_W-1:0] d_flags;

  assign in_ready   = !valid_q || out_ready;
  assign issue_fire = in_valid && in_ready;
  assign res_fire   = valid_q && out_ready;
  assign out_valid  = valid_q;
  assign out_data   = res_q;
  assign out_flags  = flags_q;
  assign status     = status_q;
  assign fwd_en     = valid_q && w_q && !is_zr(da_q);

  // Operand read: zero register beats forwarding, forwarding beats the array
  always_comb begin
    opa  = regs[in_sa];
    breg = regs[in_sb];
    if (fwd_en && (da_q == in_sa)) opa = res_q;
    if (fwd_en && (da_q == in_sb)) breg = res_q;
    if (is_zr(in_sa)) opa = '0;
    if (is_zr(in_sb)) breg = '0;
    opb = in_ksel ? in_k : breg;
  end

  alu_param #(
    .DATA_W (DATA_W)
  ) u_alu (
    .a     (opa),
    .b     (opb),
    .fs    (in_fs),
    .c0    (in_c0),
    .f     (alu_f),
    .flags (alu_flags)
  );

  // Flags describe the value actually registered; the pass path has no C/V
  always_comb begin
    d       = alu_f;
    d_flags = alu_flags;
    if (in_dsel) begin
      d               = breg;
      d_flags         = '0;
      d_flags[FLAG_Z] = (breg == '0);
      d_flags[FLAG_N] = breg[DATA_W-1];
    end
  end

  assign dbg_data = is_zr(dbg_addr) ? '0 : regs[dbg_addr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < int'(NREGS); i++) regs[i] <= '0;
      res_q    <= '0;
      flags_q  <= '0;
      status_q <= '0;
      da_q     <= '0;
      w_q      <= 1'b0;
      sf_q     <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      if (issue_fire) begin
        res_q   <= d;
        flags_q <= d_flags;
        da_q    <= in_da;
        w_q     <= in_w;
        sf_q    <= in_sf;
        valid_q <= 1'b1;
      end else if (res_fire) begin
        valid_q <= 1'b0;
      end
      if (res_fire) begin
        if (w_q && !is_zr(da_q)) regs[da_q] <= res_q;
        if (sf_q) status_q <= flags_q;
      end
    end
  end

endmodule

// File: tb/tb_regfile_alu_pipe.sv
// Directed-vector bench for regfile_alu_pipe with hand-computed expectations.
module tb_regfile_alu_pipe;

  localparam int unsigned DW = 64;
  localparam int unsigned AWL = 5;
  localparam logic [4:0] ZR  = 5'd31;
  localparam logic [4:0] ADD = 5'b01000;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [AWL-1:0] in_sa, in_sb, in_da;
  logic [4:0]    in_fs;
  logic          in_c0;
  logic [DW-1:0] in_k;
  logic          in_ksel, in_dsel, in_w, in_sf;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [3:0]    out_flags;
  logic [3:0]    status;
  logic [AWL-1:0] dbg_addr;
  logic [DW-1:0] dbg_data;

  int unsigned n_vec;
  int unsigned n_miss;

  regfile_alu_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sa     (in_sa),
    .in_sb     (in_sb),
    .in_da     (in_da),
    .in_fs     (in_fs),
    .in_c0     (in_c0),
    .in_k      (in_k),
    .in_ksel   (in_ksel),
    .in_dsel   (in_dsel),
    .in_w      (in_w),
    .in_sf     (in_sf),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_flags (out_flags),
    .status    (status),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic op(input logic [4:0] sa, input logic [4:0] sb, input logic [4:0] da,
                    input logic [4:0] fs, input logic c0, input logic [63:0] k,
                    input logic ksel, input logic dsel, input logic w, input logic sf);
    in_sa    = sa;
    in_sb    = sb;
    in_da    = da;
    in_fs    = fs;
    in_c0    = c0;
    in_k     = k;
    in_ksel  = ksel;
    in_dsel  = dsel;
    in_w     = w;
    in_sf    = sf;
    in_valid = 1'b1;
  endtask

  task automatic rd(input logic [4:0] a, input string tag, input logic [63:0] exp);
    dbg_addr = a;
    #1;
    check(tag, dbg_data, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_vec     = 0;
    n_miss    = 0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dbg_addr  = '0;
    op(5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    in_valid  = 1'b0;

    // reset and debug reads
    step();
    step();
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_status", 64'(status), 64'd0);
    for (int i = 0; i < 32; i++) rd(5'(i), "rst_reg", 64'd0);
    rst = 1'b1;
    step();

    // constant load
    op(ZR, 5'd0, 5'd1, ADD, 1'b0, 64'd5, 1'b1, 1'b0, 1'b1, 1'b0);
    #1 check("rdy_idle", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    check("k_valid", 64'(out_valid), 64'd1);
    check("k_data", out_data, 64'd5);
    check("k_flags", 64'(out_flags), 64'd0);
    rd(5'd1, "r1_before_fire", 64'd0);
    out_ready = 1'b1;
    step();
    check("k_drain", 64'(out_valid), 64'd0);
    rd(5'd1, "r1", 64'd5);

    // back-to-back forwarding
    op(5'd1, 5'd1, 5'd2, ADD, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    check("x2", out_data, 64'd10);
    op(5'd2, 5'd1, 5'd3, ADD, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    check("x3_fwd", out_data, 64'd15);
    rd(5'd2, "r2", 64'd10);
    in_valid = 1'b0;
    step();
    check("b2b_drain", 64'(out_valid), 64'd0);
    rd(5'd3, "r3", 64'd15);

    // backpressure
    out_ready = 1'b0;
    op(5'd3, 5'd0, 5'd4, ADD, 1'b0, 64'd1, 1'b1, 1'b0, 1'b1, 1'b1);
    step();
    check("x4", out_data, 64'd16);
    op(5'd4, 5'd4, 5'd5, ADD, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      #1;
      check("bp_ready", 64'(in_ready), 64'd0);
      check("bp_hold", out_data, 64'd16);
      check("bp_status", 64'(status), 64'd0);
      rd(5'd4, "bp_nowrite", 64'd0);
      step();
    end
    out_ready = 1'b1;
    #1 check("bp_release", 64'(in_ready), 64'd1);
    step();
    check("x5_both_fwd", out_data, 64'd32);
    rd(5'd4, "r4", 64'd16);
    check("x4_status", 64'(status), 64'd0);
    op(5'd5, 5'd0, 5'd6, ADD, 1'b0, 64'd3, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    check("x6", out_data, 64'd35);
    rd(5'd5, "r5", 64'd32);
    in_valid = 1'b0;
    step();
    rd(5'd6, "r6", 64'd35);

    // subtract and status
    out_ready = 1'b0;
    op(ZR, 5'd0, 5'd7, 5'b01001, 1'b1, 64'd1, 1'b1, 1'b0, 1'b1, 1'b1);
    step();
    in_valid = 1'b0;
    check("sub_data", out_data, ONES);
    check("sub_flags", 64'(out_flags), 64'b0010);
    check("sub_status_held", 64'(status), 64'd0);
    out_ready = 1'b1;
    step();
    check("sub_status", 64'(status), 64'b0010);
    rd(5'd7, "r7", ONES);

    op(ZR, 5'd0, 5'd8, ADD, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    op(5'd8, 5'd0, 5'd9, ADD, 1'b0, 64'd1, 1'b1, 1'b0, 1'b1, 1'b1);
    step();
    check("ovf_data", out_data, 64'h8000_0000_0000_0000);
    check("ovf_flags", 64'(out_flags), 64'b1010);
    check("ovf_status_prev", 64'(status), 64'b0010);
    op(5'd7, 5'd0, 5'd10, ADD, 1'b0, 64'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    check("ovf_status", 64'(status), 64'b1010);
    check("carry_data", out_data, 64'd0);
    check("carry_flags", 64'(out_flags), 64'b0101);
    op(5'd1, 5'd0, 5'd11, 5'b10000, 1'b0, 64'd65, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    check("shl_wrap", out_data, 64'd10);
    op(5'd8, 5'd0, 5'd11, 5'b10100, 1'b0, 64'd60, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    check("shr", out_data, 64'd7);
    op(5'd1, 5'd0, 5'd11, 5'b00010, 1'b0, 64'hF, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    check("and_inva", out_data, 64'hA);
    op(5'd7, 5'd7, 5'd11, ADD, 1'b0, 64'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    check("dsel_data", out_data, ONES);
    check("dsel_flags", 64'(out_flags), 64'b0010);
    in_valid = 1'b0;
    step();
    rd(5'd9, "r9", 64'h8000_0000_0000_0000);

    // zero register
    op(ZR, 5'd0, ZR, ADD, 1'b0, 64'd7, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    check("zr_data", out_data, 64'd7);
    op(ZR, ZR, 5'd12, ADD, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    check("zr_nofwd", out_data, 64'd0);
    in_valid = 1'b0;
    step();
    rd(ZR, "zr_read", 64'd0);
    rd(5'd12, "r12", 64'd0);

    // reset with an op in flight
    out_ready = 1'b0;
    op(ZR, 5'd0, 5'd13, ADD, 1'b0, 64'd9, 1'b1, 1'b0, 1'b1, 1'b1);
    step();
    in_valid = 1'b0;
    check("mid_valid", 64'(out_valid), 64'd1);
    check("mid_data", out_data, 64'd9);
    out_ready = 1'b1;
    rst = 1'b0;
    step();
    check("mr_valid", 64'(out_valid), 64'd0);
    check("mr_status", 64'(status), 64'd0);
    check("mr_data", out_data, 64'd0);
    rd(5'd13, "mr_r13", 64'd0);
    rd(5'd9, "mr_r9", 64'd0);
    rst = 1'b1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
